// File: rtl/eth_gmii_monitor.sv
// Transmit-side GMII/MII frame monitor: preamble/SFD sync, CRC-32 check, header capture, frame counters.
// Define ETH_MON_PAYLOAD_CHECK_EN to compile in the incrementing payload pattern checker.
//
// state    | meaning
// IDLE     | waiting for tx_en; first value must be preamble
// PREAMBLE | consuming 0x55 until the SFD
// DATA     | bytes after SFD: CRC, length, header capture
// DRAIN    | bad start of frame; wait for tx_en low
module eth_gmii_monitor #(
    parameter int MAX_FRAME = 1518
) (
    input  logic        tx_clk,
    input  logic        reset,
    input  logic        mii_mode,
    input  logic [7:0]  txd,
    input  logic        tx_en,
    input  logic        tx_er,
    input  logic [7:0]  cntstart,
    input  logic [7:0]  cntstep,
    output logic        frame_done,
    output logic [15:0] frame_len,
    output logic [47:0] dst,
    output logic [47:0] src,
    output logic [15:0] frmtype,
    output logic        crc_ok,
    output logic [4:0]  err_flags,
    output logic [31:0] good_cnt,
    output logic [31:0] bad_cnt
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DRAIN} state_t;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;
    localparam int unsigned MAX_LEN     = MAX_FRAME;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    // The shift-right register holds the residue bit-reversed.
    function automatic logic [31:0] rev32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    state_t      state_q, state_d;
    logic        nib_ph_q, nib_ph_d;
    logic [3:0]  nib_lo_q, nib_lo_d;
    logic [31:0] crc_q, crc_d;
    logic [15:0] len_q, len_d;
    logic [47:0] dst_w_q, dst_w_d, src_w_q, src_w_d;
    logic [15:0] type_w_q, type_w_d;
    logic        phy_w_q, phy_w_d;
    logic        frame_done_q, frame_done_d;
    logic [15:0] frame_len_q, frame_len_d;
    logic [47:0] dst_q, dst_d, src_q, src_d;
    logic [15:0] frmtype_q, frmtype_d;
    logic        crc_ok_q, crc_ok_d;
    logic [4:0]  err_q, err_d;
    logic [31:0] good_q, good_d, bad_q, bad_d;

    logic        byte_vld;
    logic [7:0]  byte_val;
    logic        frame_end;
    logic        end_crc_ok;
    logic [4:0]  end_err;
    logic        pay_err;

`ifdef ETH_MON_PAYLOAD_CHECK_EN
    logic [3:0]  pe_q, pe_d;
    logic        pay_w_q, pay_w_d;
    logic [7:0]  exp_q, exp_d;
    logic [15:0] pay_start;
    logic        pay_mis;

    // Per-byte mismatches are delayed 4 bytes so the FCS never counts as payload.
    always_comb begin
        pay_start = (type_w_q == 16'h8100) ? 16'd18 : 16'd14;
        pay_mis   = 1'b0;
        pe_d      = pe_q;
        pay_w_d   = pay_w_q;
        exp_d     = exp_q;
        if (state_q != DATA) begin
            pe_d    = '0;
            pay_w_d = 1'b0;
        end else if (byte_vld) begin
            if (len_q >= pay_start) begin
                pay_mis = byte_val != ((len_q == pay_start) ? cntstart : exp_q);
                exp_d   = byte_val + cntstep;
            end
            pe_d    = {pe_q[2:0], pay_mis};
            pay_w_d = pay_w_q | pe_q[3];
        end
    end

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            pe_q    <= '0;
            pay_w_q <= 1'b0;
            exp_q   <= '0;
        end else begin
            pe_q    <= pe_d;
            pay_w_q <= pay_w_d;
            exp_q   <= exp_d;
        end
    end

    assign pay_err = pay_w_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{cntstart, cntstep};
    assign pay_err    = 1'b0;
`endif

    always_comb begin
        byte_vld   = tx_en && (state_q == DATA) && (!mii_mode || nib_ph_q);
        byte_val   = mii_mode ? {txd[3:0], nib_lo_q} : txd;
        frame_end  = !tx_en && (state_q != IDLE);
        end_crc_ok = (state_q == DATA) && (rev32(crc_q) == CRC_RESIDUE);
        end_err    = {pay_err,
                      mii_mode && nib_ph_q && (state_q == DATA),
                      32'(len_q) > MAX_LEN,
                      len_q < 16'd64,
                      phy_w_q};

        state_d      = state_q;
        nib_ph_d     = nib_ph_q;
        nib_lo_d     = nib_lo_q;
        crc_d        = crc_q;
        len_d        = len_q;
        dst_w_d      = dst_w_q;
        src_w_d      = src_w_q;
        type_w_d     = type_w_q;
        phy_w_d      = phy_w_q;
        frame_done_d = 1'b0;
        frame_len_d  = frame_len_q;
        dst_d        = dst_q;
        src_d        = src_q;
        frmtype_d    = frmtype_q;
        crc_ok_d     = crc_ok_q;
        err_d        = err_q;
        good_d       = good_q;
        bad_d        = bad_q;

        case (state_q)
            IDLE: begin
                nib_ph_d = 1'b0;
                crc_d    = CRC_INIT;
                len_d    = '0;
                dst_w_d  = '0;
                src_w_d  = '0;
                type_w_d = '0;
                phy_w_d  = 1'b0;
                if (tx_en) begin
                    phy_w_d = tx_er;
                    if (mii_mode ? (txd[3:0] == 4'h5) : (txd == 8'h55)) begin
                        state_d = PREAMBLE;
                    end else begin
                        state_d = DRAIN;
                        phy_w_d = 1'b1;
                    end
                end
            end
            PREAMBLE: if (tx_en) begin
                phy_w_d = phy_w_q | tx_er;
                if (mii_mode ? (txd[3:0] == 4'hD) : (txd == 8'hD5))
                    state_d = DATA;
                else if (!(mii_mode ? (txd[3:0] == 4'h5) : (txd == 8'h55)))
                    state_d = DRAIN;
            end
            DATA: if (tx_en) begin
                phy_w_d = phy_w_q | tx_er;
                if (mii_mode) begin
                    nib_ph_d = !nib_ph_q;
                    if (!nib_ph_q) nib_lo_d = txd[3:0];
                end
                if (byte_vld) begin
                    crc_d = crc_byte(crc_q, byte_val);
                    len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
                    if (len_q < 16'd6)       dst_w_d  = {dst_w_q[39:0], byte_val};
                    else if (len_q < 16'd12) src_w_d  = {src_w_q[39:0], byte_val};
                    else if (len_q < 16'd14) type_w_d = {type_w_q[7:0], byte_val};
                end
            end
            DRAIN: if (tx_en) phy_w_d = phy_w_q | tx_er;
            default: state_d = IDLE;
        endcase

        if (frame_end) begin
            state_d      = IDLE;
            frame_done_d = 1'b1;
            frame_len_d  = len_q;
            dst_d        = dst_w_q;
            src_d        = src_w_q;
            frmtype_d    = type_w_q;
            crc_ok_d     = end_crc_ok;
            err_d        = end_err;
            if (end_crc_ok && (end_err == 5'd0)) good_d = good_q + 32'd1;
            else                                 bad_d  = bad_q + 32'd1;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state_q      <= IDLE;
            nib_ph_q     <= 1'b0;
            nib_lo_q     <= '0;
            crc_q        <= CRC_INIT;
            len_q        <= '0;
            dst_w_q      <= '0;
            src_w_q      <= '0;
            type_w_q     <= '0;
            phy_w_q      <= 1'b0;
            frame_done_q <= 1'b0;
            frame_len_q  <= '0;
            dst_q        <= '0;
            src_q        <= '0;
            frmtype_q    <= '0;
            crc_ok_q     <= 1'b0;
            err_q        <= '0;
            good_q       <= '0;
            bad_q        <= '0;
        end else begin
            state_q      <= state_d;
            nib_ph_q     <= nib_ph_d;
            nib_lo_q     <= nib_lo_d;
            crc_q        <= crc_d;
            len_q        <= len_d;
            dst_w_q      <= dst_w_d;
            src_w_q      <= src_w_d;
            type_w_q     <= type_w_d;
            phy_w_q      <= phy_w_d;
            frame_done_q <= frame_done_d;
            frame_len_q  <= frame_len_d;
            dst_q        <= dst_d;
            src_q        <= src_d;
            frmtype_q    <= frmtype_d;
            crc_ok_q     <= crc_ok_d;
            err_q        <= err_d;
            good_q       <= good_d;
            bad_q        <= bad_d;
        end
    end

    assign frame_done = frame_done_q;
    assign frame_len  = frame_len_q;
    assign dst        = dst_q;
    assign src        = src_q;
    assign frmtype    = frmtype_q;
    assign crc_ok     = crc_ok_q;
    assign err_flags  = err_q;
    assign good_cnt   = good_q;
    assign bad_cnt    = bad_q;
endmodule

// File: tb/tb_eth_gmii_monitor.sv
// Scoreboard bench for eth_gmii_monitor: directed and random frames checked against a byte-level reference model.
module tb_eth_gmii_monitor;
    logic        tx_clk = 1'b0;
    logic        reset = 1'b1;
    logic        mii_mode = 1'b0;
    logic [7:0]  txd = 8'h00;
    logic        tx_en = 1'b0;
    logic        tx_er = 1'b0;
    logic [7:0]  cntstart = 8'h00;
    logic [7:0]  cntstep = 8'h01;
    logic        frame_done;
    logic [15:0] frame_len;
    logic [47:0] dst, src;
    logic [15:0] frmtype;
    logic        crc_ok;
    logic [4:0]  err_flags;
    logic [31:0] good_cnt, bad_cnt;

    eth_gmii_monitor #(.MAX_FRAME(1518)) dut (
        .tx_clk(tx_clk), .reset(reset), .mii_mode(mii_mode), .txd(txd),
        .tx_en(tx_en), .tx_er(tx_er), .cntstart(cntstart), .cntstep(cntstep),
        .frame_done(frame_done), .frame_len(frame_len), .dst(dst), .src(src),
        .frmtype(frmtype), .crc_ok(crc_ok), .err_flags(err_flags),
        .good_cnt(good_cnt), .bad_cnt(bad_cnt)
    );

    always #5 tx_clk = ~tx_clk;

    longint cyc = 0;
    always @(posedge tx_clk) cyc <= cyc + 1;

    typedef struct {
        longint      done_cyc;
        logic [15:0] len;
        logic [47:0] dst;
        logic [47:0] src;
        logic [15:0] typ;
        logic        crc_ok;
        logic [4:0]  err;
        logic [31:0] good;
        logic [31:0] bad;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic [7:0]  fb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_good = 0, m_bad = 0;
    logic        cur_mii = 1'b0;
    logic        prev_done = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Standard Ethernet CRC-32 over fb[0..n-1], bit-serial LSB first, final inversion.
    function automatic logic [31:0] crc32_ref(input int n);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < n; i++)
            for (int b = 0; b < 8; b++)
                c = (c[0] ^ fb[i][b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        return ~c;
    endfunction

    task automatic build(input int n, input logic [47:0] d, input logic [15:0] typ,
                         input int corrupt, input bit bad_fcs);
        logic [47:0] s;
        logic [31:0] f;
        int          start;
        s[47:16] = $urandom();
        s[15:0]  = 16'($urandom());
        fb.delete();
        for (int i = 0; i < 6; i++) fb.push_back(d[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) fb.push_back(s[47-8*i -: 8]);
        fb.push_back(typ[15:8]);
        fb.push_back(typ[7:0]);
        start = (typ == 16'h8100) ? 18 : 14;
        for (int i = 14; i < n - 4; i++)
            if (i < start) fb.push_back(8'($urandom()));
            else           fb.push_back(8'(int'(cntstart) + (i - start) * int'(cntstep)));
        if (corrupt >= 0) fb[corrupt] = fb[corrupt] ^ 8'hFF;
        f = crc32_ref(n - 4);
        for (int k = 0; k < 4; k++) fb.push_back(f[8*k +: 8]);
        if (bad_fcs) fb[n-1] = fb[n-1] ^ 8'h01;
    endtask

    task automatic push_exp(input bit er, input bit extra);
        exp_t        e;
        int          n, start;
        logic [31:0] fcs;
        logic        pe;
        logic [7:0]  want;
        n = fb.size();
        e.done_cyc = cyc + 1;
        e.len = (n > 65535) ? 16'hFFFF : 16'(n);
        e.dst = '0; e.src = '0; e.typ = '0;
        for (int i = 0; i < 6; i++) e.dst = {e.dst[39:0], fb[i]};
        for (int i = 6; i < 12; i++) e.src = {e.src[39:0], fb[i]};
        e.typ = {fb[12], fb[13]};
        fcs = {fb[n-1], fb[n-2], fb[n-3], fb[n-4]};
        e.crc_ok = (crc32_ref(n - 4) == fcs);
        pe = 1'b0;
        start = (e.typ == 16'h8100) ? 18 : 14;
`ifdef ETH_MON_PAYLOAD_CHECK_EN
        for (int i = start; i < n - 4; i++) begin
            want = (i == start) ? cntstart : 8'(fb[i-1] + cntstep);
            if (fb[i] != want) pe = 1'b1;
        end
`else
        want = 8'h00;
`endif
        e.err = {pe, extra, n > 1518, n < 64, er};
        if (e.crc_ok && e.err == 5'd0) m_good++; else m_bad++;
        e.good = m_good;
        e.bad  = m_bad;
        sb.push_back(e);
    endtask

    task automatic sym(input logic [7:0] v, input logic er);
        @(posedge tx_clk); #1;
        mii_mode = cur_mii;
        tx_en = 1'b1;
        txd = v;
        tx_er = er;
    endtask

    task automatic send(input bit mii, input int er_idx, input bit extra, input int abort_at);
        logic er;
        cur_mii = mii;
        if (mii) begin
            for (int i = 0; i < 15; i++) sym({4'($urandom()), 4'h5}, 1'b0);
            sym({4'($urandom()), 4'hD}, 1'b0);
        end else begin
            for (int i = 0; i < 7; i++) sym(8'h55, 1'b0);
            sym(8'hD5, 1'b0);
        end
        for (int i = 0; i < fb.size(); i++) begin
            if (i == abort_at) begin
                @(posedge tx_clk); #1;
                reset = 1'b1; tx_en = 1'b0; tx_er = 1'b0;
                repeat (2) @(posedge tx_clk);
                #1 reset = 1'b0;
                return;
            end
            er = (i == er_idx);
            if (mii) begin
                sym({4'($urandom()), fb[i][3:0]}, er);
                sym({4'($urandom()), fb[i][7:4]}, 1'b0);
            end else begin
                sym(fb[i], er);
            end
        end
        if (mii && extra) sym(8'($urandom()), 1'b0);
        @(posedge tx_clk); #1;
        tx_en = 1'b0; tx_er = 1'b0; txd = 8'($urandom());
        push_exp(er_idx >= 0 && er_idx < fb.size(), mii && extra);
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge tx_clk);
    endtask

    task automatic chk_reset_state();
        @(negedge tx_clk);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_len", frame_len, 0);
        chk("rst_dst", dst, 0);
        chk("rst_src", src, 0);
        chk("rst_frmtype", frmtype, 0);
        chk("rst_crc_ok", crc_ok, 0);
        chk("rst_err_flags", err_flags, 0);
        chk("rst_good_cnt", good_cnt, 0);
        chk("rst_bad_cnt", bad_cnt, 0);
    endtask

    // Monitor: pops the scoreboard whenever the DUT reports a frame.
    initial begin
        forever begin
            @(negedge tx_clk);
            if (reset) begin
                prev_done = 1'b0;
            end else begin
                if (frame_done) begin
                    chk("done_single_cycle", prev_done, 0);
                    if (sb.size() == 0) begin
                        chk("unexpected_done", frame_done, 0);
                    end else begin
                        mon_e = sb.pop_front();
                        chk("done_cycle", cyc, mon_e.done_cyc);
                        chk("frame_len", frame_len, mon_e.len);
                        chk("dst", dst, mon_e.dst);
                        chk("src", src, mon_e.src);
                        chk("frmtype", frmtype, mon_e.typ);
                        chk("crc_ok", crc_ok, mon_e.crc_ok);
                        chk("err_flags", err_flags, mon_e.err);
                        chk("good_cnt", good_cnt, mon_e.good);
                        chk("bad_cnt", bad_cnt, mon_e.bad);
                    end
                end else if (sb.size() > 0 && cyc > sb[0].done_cyc) begin
                    chk("missing_done", frame_done, 1);
                    void'(sb.pop_front());
                end
                prev_done = frame_done;
            end
        end
    end

    initial begin
        exp_t        de;
        int          n, er_i, cor;
        logic [15:0] typ;
        logic [47:0] d;
        bit          mii, bad, ext;

        repeat (4) @(posedge tx_clk);
        #1 reset = 1'b0;
        chk_reset_state();

        cntstart = 8'h00; cntstep = 8'h01;
        build(64, 48'h001122334455, 16'h0800, -1, 0); send(0, -1, 0, -1); idle(3);
        build(64, 48'h001122334455, 16'h0800, -1, 1); send(0, -1, 0, -1); idle(3);
        build(64, 48'h001122334455, 16'h0800, -1, 0); send(1, -1, 0, -1); idle(3);
        build(64, 48'h001122334455, 16'h0800, -1, 0); send(1, -1, 1, -1); idle(3);
        build(64, 48'h001122334455, 16'h0800, -1, 0); send(0, 20, 0, -1); idle(3);
        build(60, 48'h001122334455, 16'h0800, -1, 0); send(0, -1, 0, -1); idle(3);
        build(1522, 48'h001122334455, 16'h0800, -1, 0); send(0, -1, 0, -1); idle(3);

        // back-to-back frames separated by a single idle cycle
        build(64, 48'h001122334455, 16'h0800, -1, 0); send(0, -1, 0, -1);
        build(64, 48'h001122334455, 16'h0800, -1, 0); send(0, -1, 0, -1);
        build(70, 48'h0A0B0C0D0E0F, 16'h0800, -1, 0); send(1, -1, 0, -1); idle(3);

        // bad first byte goes straight to drain
        cur_mii = 1'b0;
        sym(8'h12, 1'b0); sym(8'h55, 1'b0); sym(8'hD5, 1'b0);
        @(posedge tx_clk); #1 tx_en = 1'b0;
        de.done_cyc = cyc + 1; de.len = '0; de.dst = '0; de.src = '0; de.typ = '0;
        de.crc_ok = 1'b0; de.err = 5'b00011; m_bad++; de.good = m_good; de.bad = m_bad;
        sb.push_back(de);
        idle(3);

        // reset mid-frame: no report, counters restart, next frame clean
        build(64, 48'h001122334455, 16'h0800, -1, 0); send(0, -1, 0, 30);
        m_good = 0; m_bad = 0;
        chk_reset_state();
        build(64, 48'h001122334455, 16'h0800, -1, 0); send(0, -1, 0, -1); idle(3);

        build(64, 48'h001122334455, 16'h0800, 40, 0); send(0, -1, 0, -1); idle(3);
        build(90, 48'h001122334455, 16'h8100, 16, 0); send(1, -1, 0, -1); idle(3);
        build(90, 48'h001122334455, 16'h8100, 30, 0); send(0, -1, 0, -1); idle(3);

        for (int t = 0; t < 30; t++) begin
            cntstart = 8'($urandom()); cntstep = 8'($urandom());
            n   = $urandom_range(40, 200);
            mii = 1'($urandom());
            bad = ($urandom_range(0, 3) == 0);
            ext = ($urandom_range(0, 5) == 0);
            er_i = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
            cor  = ($urandom_range(0, 3) == 0) ? $urandom_range(14, n - 5) : -1;
            case ($urandom_range(0, 2))
                0:       typ = 16'h0800;
                1:       typ = 16'h8100;
                default: typ = 16'($urandom());
            endcase
            d[47:16] = $urandom(); d[15:0] = 16'($urandom());
            build(n, d, typ, cor, bad);
            send(mii, er_i, ext, -1);
            idle($urandom_range(0, 4));
        end

        for (int t = 0; t < 200 && sb.size() > 0; t++) @(posedge tx_clk);
        if (sb.size() > 0) chk("scoreboard_drain_timeout", 64'(sb.size()), 0);
        idle(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/eth_gmii_monitor.md
ETH_GMII_MONITOR -- requirements
Module: eth_gmii_monitor

Interface
REQ-001 Parameter MAX_FRAME, default 1518, sets the byte count above which a frame is flagged too long.
REQ-002 Port tx_clk, input, 1 bit, is the sole clock; all logic is on its rising edge.
REQ-003 Port reset, input, 1 bit, is a synchronous, active-high reset.
REQ-004 Port mii_mode, input, 1 bit: 1 = 4-bit nibble on txd[3:0], low nibble first; 0 = 8-bit GMII byte.
REQ-005 Port txd, input, 8 bits, is the data from the MAC transmit side.
REQ-006 Port tx_en, input, 1 bit, is the data-valid strobe from the MAC.
REQ-007 Port tx_er, input, 1 bit, is the MAC transmit error.
REQ-008 Port cntstart, input, 8 bits, is the expected first payload byte.
REQ-009 Port cntstep, input, 8 bits, is the expected payload increment.
REQ-010 Port frame_done, output, 1 bit, pulses once per completed frame.
REQ-011 Port frame_len, output, 16 bits, gives the bytes after SFD, FCS included.
REQ-012 Port dst, output, 48 bits, and port src, output, 48 bits, give the captured addresses, first wire byte in bits [47:40].
REQ-013 Port frmtype, output, 16 bits, gives bytes 13-14 after SFD.
REQ-014 Port crc_ok, output, 1 bit, is the FCS check result.
REQ-015 Port err_flags, output, 5 bits: {payload_err, align_err, long_err, short_err, phy_err}.
REQ-016 Port good_cnt, output, 32 bits, and port bad_cnt, output, 32 bits, are frame counters.

Function
REQ-017 The FSM states are IDLE, PREAMBLE, DATA and DRAIN; after reset the state is IDLE.
REQ-018 IDLE -> PREAMBLE on the first tx_en=1 byte (or nibble) equal to 0x55 (0x5).
REQ-019 Any other first value goes IDLE -> DRAIN with phy_err set.
REQ-020 PREAMBLE -> DATA on SFD: byte 0xD5, or nibble 0x5 followed by nibble 0xD.
REQ-021 A value other than 0x55 or the SFD in PREAMBLE goes to DRAIN.
REQ-022 DRAIN waits for tx_en=0, then issues frame_done with crc_ok=0.
REQ-023 MII mode: nibbles are paired into bytes, first nibble to bits [3:0]; one byte is produced every second tx_en cycle.
REQ-024 In DATA, each assembled byte updates CRC-32 (reflected, polynomial 0x04C11DB7, init 0xFFFFFFFF) and increments the byte counter, which saturates at 0xFFFF.
REQ-025 crc_ok=1 when the CRC residue after the last byte equals 0xC704DD7B.
REQ-026 tx_en falling in DATA or DRAIN registers all results, then pulses frame_done for exactly 1 cycle on the next edge (latency 1 cycle after the first tx_en=0 sample).
REQ-027 frame_len, dst, src, frmtype, crc_ok and err_flags hold their values until the next frame_done.
REQ-028 phy_err is set if tx_er=1 on any cycle with tx_en=1.
REQ-029 align_err is set in MII mode on an odd nibble count after SFD; the trailing nibble is discarded.
REQ-030 short_err is set when frame_len < 64; long_err is set when frame_len > MAX_FRAME.
REQ-031 good_cnt increments on frame_done when crc_ok=1 and err_flags=0; otherwise bad_cnt increments.
REQ-032 Both counters wrap from 0xFFFFFFFF to 0.
REQ-033 tx_en reasserting on the cycle immediately after frame_done starts a new frame with no lost byte.
REQ-034 Changing mii_mode outside IDLE has undefined results; the bench does not change it mid-frame.

Reset
REQ-035 Reset forces the following outputs to 0: frame_done, frame_len, dst, src, frmtype, crc_ok, err_flags, good_cnt and bad_cnt.
REQ-036 Reset forces the FSM to IDLE, sets the CRC register to 0xFFFFFFFF, and clears the nibble phase.
REQ-037 Reset asserted mid-frame aborts the frame with no frame_done; the monitor resynchronises on the next preamble.

Configuration
REQ-038 Macro ETH_MON_PAYLOAD_CHECK_EN, when defined, compiles in the payload pattern checker.
REQ-039 Payload checking applies to bytes from offset 14 (offset 18 when frmtype==0x8100) up to frame_len-4: the first byte must equal cntstart and each next byte must equal the previous byte plus cntstep, mod 256.
REQ-040 Any payload mismatch sets payload_err.
REQ-041 When the macro is undefined, the checker logic is absent and err_flags[4] is tied to 0.

Verification
REQ-042 GMII: 7x0x55, 0xD5, 64-byte frame with valid FCS, dst=0x001122334455, cntstart=0x00, cntstep=0x01 -> frame_done 1 cycle after tx_en falls, frame_len=64, crc_ok=1, err_flags=0, good_cnt=1.
REQ-043 The same frame with the last FCS byte XOR 0x01 -> crc_ok=0 and bad_cnt=1.
REQ-044 MII mode, same frame sent as nibbles -> identical results to the GMII case.
REQ-045 MII frame with one extra trailing nibble -> align_err=1.
REQ-046 tx_er pulsed on byte 20 -> phy_err=1.
REQ-047 A 60-byte frame gives short_err=1, and a 1522-byte frame gives long_err=1.
REQ-048 Back-to-back frames with a 1-cycle tx_en gap -> 2 frame_done pulses and good_cnt=2.
REQ-049 Reset asserted at byte 30 -> no frame_done; the next frame is reported correctly.
REQ-050 With ETH_MON_PAYLOAD_CHECK_EN defined, payload byte 40 corrupted -> payload_err=1; with the macro undefined, payload_err=0.
